wr_cfg_sequencer: RTL and testbench

Sequencer for the write-memory controller configuration table. It holds a ROM_DEPTH x ROM_WIDTH configuration store, loaded over a simple write port at boot from the `.mif`-derived image. On a start pulse it issues the first N entries in order to the write datapath over a valid/ready command port. After each command it waits for the datapath's completion pulse before issuing the next, and optionally repeats the whole table.

---
 rtl/wr_cfg_sequencer.sv | 149 ++++++++++++++
 tb/tb_wr_cfg_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_cfg_sequencer.sv
// Configuration-table sequencer: issues the first N table entries over a valid/ready
// command port, one per op_done, optionally repeating. Watchdog: define CFG_SEQ_TIMEOUT_EN.
module wr_cfg_sequencer #(
    parameter int ROM_DEPTH      = 8,
    parameter int ROM_WIDTH      = 118,
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [ROM_WIDTH-1:0]  cfg_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_entries,
    input  logic [7:0]            loop_count,
    output logic                  cmd_valid,
    output logic [ROM_WIDTH-1:0]  cmd_data,
    input  logic                  cmd_ready,
    input  logic                  op_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] cur_idx
);

    // state     | meaning
    // IDLE      | waiting for start; table writable
    // FETCH     | registered read of entry idx into cmd_data
    // ISSUE     | cmd_valid high until cmd_ready
    // WAIT_DONE | waiting for the datapath completion pulse
    // FIN       | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_DONE, FIN} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_N = (ADDR_WIDTH+1)'(ROM_DEPTH);

    state_t                state;
    logic [ROM_WIDTH-1:0]  table_mem [ROM_DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [7:0]            pass;
    logic [7:0]            loops;
    logic [ADDR_WIDTH:0]   n_clamped;

    assign n_clamped = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
    assign cur_idx   = idx;

`ifdef CFG_SEQ_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wait_cnt;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Table has no reset: the boot image must survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE)
            table_mem[cfg_addr] <= cfg_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            last_idx  <= '0;
            pass      <= '0;
            loops     <= '0;
`ifdef CFG_SEQ_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last_idx <= ADDR_WIDTH'(n_clamped - 1'b1);
                        loops    <= loop_count;
                        idx      <= '0;
                        pass     <= '0;
                        busy     <= 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                        if (n_clamped == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    cmd_data  <= table_mem[idx];
                    cmd_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_DONE;
`ifdef CFG_SEQ_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
                    // op_done wins over a watchdog expiry in the same cycle
                    if (op_done) begin
                        if (idx == last_idx) begin
                            if (pass == loops) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                idx   <= '0;
                                pass  <= pass + 8'd1;
                                state <= FETCH;
                            end
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
`ifdef CFG_SEQ_TIMEOUT_EN
                    else if (wait_cnt == TMO_LAST) begin
                        err_q <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_cfg_sequencer.sv
// Directed self-checking bench for wr_cfg_sequencer; table entry i holds i*3+1.
// The watchdog scenario runs when CFG_SEQ_TIMEOUT_EN is defined (limit 16).
module tb_wr_cfg_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [117:0] cfg_data;
    logic         start;
    logic [3:0]   num_entries;
    logic [7:0]   loop_count;
    logic         cmd_valid;
    logic [117:0] cmd_data;
    logic         cmd_ready;
    logic         op_done;
    logic         busy;
    logic         done;
    logic         err;
    logic [2:0]   cur_idx;

    int checks = 0;
    int errors = 0;

    wr_cfg_sequencer #(
        .ROM_DEPTH(8), .ROM_WIDTH(118), .ADDR_WIDTH(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .num_entries(num_entries), .loop_count(loop_count),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .op_done(op_done),
        .busy(busy), .done(done), .err(err), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [117:0] ent(input int i);
        return 118'(i * 3 + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int n, input int l);
        num_entries = 4'(n);
        loop_count  = 8'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives op_done the cycle after each handshake and checks every command issued.
    // stop_idx >= 0: return right after the handshake edge of that entry.
    task automatic finish_seq(input string nm, input int n_eff, input int exp_n,
                              input bit chk_lat, input int stop_idx);
        int c = 0;
        int cyc = 0;
        int first = -1;
        bit pend = 0;
        bit got_done = 0;
        bit stopped = 0;
        while (cyc < 400 && !got_done && !stopped) begin
            op_done = pend;
            pend = 0;
            if (done) begin
                got_done = 1;
            end else begin
                if (cmd_valid && n_eff > 0) begin
                    checks++;
                    if (cmd_data !== ent(c % n_eff) || cur_idx !== 3'(c % n_eff)) begin
                        errors++;
                        $display("FAIL %s cmd%0d: data=%0d idx=%0d, required data=%0d idx=%0d",
                                 nm, c, cmd_data, cur_idx, ent(c % n_eff), c % n_eff);
                    end
                    if (first < 0) first = cyc;
                    if (stop_idx >= 0 && int'(cur_idx) == stop_idx) stopped = 1;
                    c++;
                    pend = cmd_ready;
                end
                tick();
                cyc++;
            end
        end
        op_done = 1'b0;
        if (stopped) return;
        checks++;
        if (!got_done || c != exp_n) begin
            errors++;
            $display("FAIL %s count: done_seen=%0d cmds=%0d, required done_seen=1 cmds=%0d",
                     nm, got_done, c, exp_n);
        end
        if (chk_lat) begin
            checks++;
            if ((exp_n > 0 && first != 1) || cyc != 3 * exp_n) begin
                errors++;
                $display("FAIL %s timing: first_cmd=%0d done_cyc=%0d, required first_cmd=1 done_cyc=%0d",
                         nm, first, cyc, 3 * exp_n);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL %s err: got %0b, required 0", nm, err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%0b busy=%0b, required 0 0", nm, done, busy);
        end
    endtask

    task automatic run_seq(input string nm, input int n, input int l, input int n_eff, input int exp_n);
        start_seq(n, l);
        finish_seq(nm, n_eff, exp_n, 1'b1, -1);
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
        num_entries = '0; loop_count = '0; cmd_ready = 1'b1; op_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_data !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || cur_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset: valid=%0b data=%0d busy=%0b done=%0b err=%0b idx=%0d, required all 0",
                     cmd_valid, cmd_data, busy, done, err, cur_idx);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = ent(i);
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_full_pass();
        run_seq("full_pass", 8, 0, 8, 8);
    endtask

    task automatic test_loop();
        run_seq("loop3x3", 3, 2, 3, 9);
    endtask

    task automatic test_bounds();
        run_seq("zero_entries", 0, 0, 0, 0);
        run_seq("clamp12", 12, 0, 8, 8);
    endtask

    task automatic test_backpressure();
        start_seq(8, 0);
        cmd_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== ent(0) || cur_idx !== 3'd0) begin
                errors++;
                $display("FAIL stall cyc%0d: valid=%0b data=%0d idx=%0d, required 1 %0d 0",
                         i, cmd_valid, cmd_data, cur_idx, ent(0));
            end
            start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 118'd999;
            tick();
        end
        start = 1'b0; cfg_we = 1'b0;
        cmd_ready = 1'b1;
        finish_seq("stall_rest", 8, 8, 1'b0, -1);
    endtask

    task automatic test_mid_reset();
        start_seq(8, 0);
        finish_seq("pre_reset", 8, 8, 1'b0, 4);
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0 || cur_idx !== 3'd4) begin
            errors++;
            $display("FAIL wait_e4: busy=%0b valid=%0b idx=%0d, required 1 0 4", busy, cmd_valid, cur_idx);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || done !== 1'b0 || cur_idx !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%0b valid=%0b done=%0b idx=%0d, required 0 0 0 0",
                     busy, cmd_valid, done, cur_idx);
        end
        for (int i = 0; i < 3; i++) begin
            op_done = 1'b1;
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle%0d: done=%0b busy=%0b, required 0 0", i, done, busy);
            end
        end
        op_done = 1'b0;
        run_seq("after_reset", 8, 0, 8, 8);
    endtask

`ifdef CFG_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        start_seq(1, 0);
        tick();
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL tmo_issue: valid=%0b, required 1", cmd_valid);
        end
        tick();
        while (!done && cnt < 40) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt != 16 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: done_after=%0d err=%0b, required 16 1", cnt, err);
        end
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: err=%0b busy=%0b, required 1 0", err, busy);
        end
        start_seq(0, 0);
        checks++;
        if (err !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%0b done=%0b, required 0 1", err, done);
        end
        tick();
    endtask
`else
    task automatic test_timeout();
        start_seq(1, 0);
        tick();
        tick();
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL no_watchdog: busy=%0b done=%0b err=%0b, required 1 0 0", busy, done, err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        load_table();
        test_full_pass();
        test_loop();
        test_bounds();
        test_backpressure();
        test_mid_reset();
        test_timeout();
        run_seq("final_pass", 8, 0, 8, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
